ws2812_stream_decoder: RTL
==========================

// Module: ws2812_stream_decoder
// PURPOSE
//  Receive end of the single-wire WS2812B LED protocol at 40 MHz. Samples the line, measures each
//  high pulse, rebuilds 24-bit colour words, and detects the >=50 us low reset/latch gap. Sits on
//  the matrix datastream for loopback checking of the LED driver, and forwards the remaining
//  words downstream the way a real LED does.
// PARAMETERS
//  HIGH_THRESH  24    high width (clk) >= this decodes as 1, below it decodes as 0 (T0H=16, T1H=32)
//  MIN_HIGH     4     high width below this is a glitch -> error
//  MAX_HIGH     64    high width reaching this is stuck-high -> error
//  RESET_LOW    1600  consecutive low clks that form a reset/latch gap (40 us)
//  CNT_W        12    width of the pulse counter; must hold RESET_LOW
// PORTS
//  clk         in   1   40 MHz clock
//  reset       in   1   synchronous, active-high reset
//  din         in   1   asynchronous WS2812B line input
//  data_out    out  24  last decoded word; first received bit lands in data_out[0]
//  data_valid  out  1   1-clk pulse when data_out has been updated
//  frame_end   out  1   1-clk pulse when a reset gap ends a frame
//  word_count  out  8   words decoded in the current/last frame, saturates at 255
//  err         out  1   1-clk pulse on a glitch, stuck-high, or partial word at frame end
//  dout        out  1   forwarded line: synchronized din once the first word of the frame is taken
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops 0; bit_idx=0; fwd=0; state=SYNC.
//  - Sampling: din passes through 2 sync flops to give s_din, which feeds an edge register.
//    Rise and fall are detected as s_din differing from its previous value.
//  - Pulse width w: the exact number of clks that s_din is high. The counter saturates at 2^CNT_W-1.
//  - FSM states: SYNC, IDLE, HIGH, LOW.
//    SYNC: ignore all pulses. After RESET_LOW consecutive low clks -> IDLE. No frame_end pulse.
//    IDLE: on rise -> HIGH. A rise in IDLE clears word_count to 0 and starts a new frame.
//    HIGH: on fall, if MIN_HIGH <= w < MAX_HIGH: bit = (w >= HIGH_THRESH).
//      Shift the bit into position bit_idx, then -> LOW.
//      If w < MIN_HIGH: err pulse, discard the partial word, bit_idx=0, fwd=0, -> SYNC.
//      If the counter reaches MAX_HIGH while still high: err pulse, same discard, -> SYNC.
//    LOW: on rise -> HIGH. On the RESET_LOW-th consecutive low clk: frame_end pulse; if bit_idx!=0,
//      also an err pulse; bit_idx=0, fwd=0, -> IDLE. word_count is held for readout at frame_end.
//  - Word completion: when the bit at bit_idx=23 is accepted, data_out and data_valid register
//    together and bit_idx wraps to 0. word_count increments (saturating). fwd is set in the same
//    cycle.
//  - Latency: data_valid is high in the clk cycle after the 3rd rising edge at which din is
//    sampled low following bit 23 (edge 1 = first low sample).
//  - Forwarding: dout = s_din & fwd, i.e. din delayed by 2 clk. The first word is consumed and
//    never forwarded (dout stays 0); words 2..N are forwarded. A pulse already in progress when fwd
//    rises is not forwarded, because dout is only enabled from the next rise.
//  - Simultaneous events: a rise on the same clk as the RESET_LOW count completes -> frame_end
//    takes priority, then IDLE handles the rise on the next edge. err and frame_end may pulse
//    together.
//  - data_out is held between words. It is not cleared by frame_end, only by reset.
//  - Reset mid-word: everything returns to reset values; no pulses are emitted.
// TESTING
//  - Reset, 2000 low clk, 24'hA5C30F LSB-first (T0H16/T0L34, T1H32/T1L18), 2000 low ->
//    data_valid once with 24'hA5C30F, then frame_end with word_count=1, err=0, dout=0 throughout.
//  - Threshold: in IDLE send 23 pulses w=16, then one pulse w=23 ->
//    data_out=24'h000000; repeat with last w=24 -> 24'h800000.
//  - Glitch: a 2-clk high mid-word -> err pulse, no data_valid. After 1600 low, a word 24'h000001
//    decodes correctly.
//  - Stuck high: 100 clk high -> err pulse when w reaches 64. Pulses are ignored until 1600
//    low clks pass.
//  - Partial: 10 bits then 2000 low -> frame_end and err in the same cycle, no data_valid,
//    word_count=0.
//  - Chain: words 24'h123456 and 24'hABCDEF back-to-back -> two data_valid pulses, word_count=2.
//    dout stays 0 during word 1 and equals din delayed 2 clk for word 2. Assert reset mid-word 2
//    -> all outputs 0.

Source files
------------

// File: rtl/ws2812_stream_decoder.sv
// ws2812_stream_decoder: WS2812B line receiver that rebuilds 24-bit words, detects latch gaps
// and forwards every word after the first of each frame, the way a chained LED does.
module ws2812_stream_decoder #(
    parameter int HIGH_THRESH = 24,
    parameter int MIN_HIGH    = 4,
    parameter int MAX_HIGH    = 64,
    parameter int RESET_LOW   = 1600,
    parameter int CNT_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        frame_end,
    output logic [7:0]  word_count,
    output logic        err,
    output logic        dout
);
    localparam logic [1:0] SYNC = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3;

    logic             r_sync1, r_sync2, r_prev, r_fwd;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit_idx;
    logic [22:0]      r_shift;
    logic [CNT_W-1:0] w_run;
    logic             w_rise, w_fall, w_gap, w_bit, w_abort, w_accept, w_word, w_end;

    // w_run is the length of the current s_din level including this clk
    assign w_run    = (r_sync2 != r_prev) ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    assign w_rise   = r_sync2 & ~r_prev;
    assign w_fall   = ~r_sync2 & r_prev;
    assign w_gap    = ~r_sync2 && (w_run >= CNT_W'(RESET_LOW));
    assign w_bit    = r_cnt >= CNT_W'(HIGH_THRESH);
    assign w_abort  = (r_state == HIGH) &&
                      ((r_sync2 && w_run >= CNT_W'(MAX_HIGH)) || (w_fall && r_cnt < CNT_W'(MIN_HIGH)));
    assign w_accept = (r_state == HIGH) && w_fall && !w_abort;
    assign w_word   = w_accept && (r_bit_idx == 5'd23);
    assign w_end    = (r_state == LOW) && w_gap;
    assign dout     = r_sync2 & r_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_fwd      <= 1'b0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_state    <= SYNC;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            r_sync1    <= din;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_cnt      <= w_run;
            data_valid <= w_word;
            frame_end  <= w_end;
            err        <= w_abort || (w_end && r_bit_idx != 5'd0);
            if (w_word) begin
                data_out   <= {w_bit, r_shift};
                word_count <= word_count + 8'(~&word_count);
                r_fwd      <= 1'b1;
                r_bit_idx  <= 5'd0;
            end else if (w_accept) begin
                r_shift[r_bit_idx] <= w_bit;
                r_bit_idx          <= r_bit_idx + 5'd1;
            end
            if (w_abort || w_end) begin
                r_bit_idx <= 5'd0;
                r_fwd     <= 1'b0;
            end
            if (r_state == IDLE && w_rise)
                word_count <= '0;
            case (r_state)
                SYNC:    r_state <= w_gap ? IDLE : SYNC;
                IDLE:    r_state <= w_rise ? HIGH : IDLE;
                HIGH:    r_state <= w_abort ? SYNC : (w_fall ? LOW : HIGH);
                default: r_state <= w_gap ? IDLE : (w_rise ? HIGH : LOW);
            endcase
        end
    end
endmodule
